fpu_arbiter: RTL and testbench

Round-robin arbiter and load sequencer that shares one FPU core among N requesters. It accepts a full operation (A, B, op) from one requester at a time. It serializes that operation onto the FPU's 16-bit `data` bus with a `start` pulse and waits for the FPU's `ready`. It then returns the result and error status to the granted requester. A watchdog counter ends any operation the FPU never completes.

---
 rtl/fpu_arbiter_if.sv | 35 +++
 rtl/fpu_arbiter.sv | 125 ++++++++++++
 tb/tb_fpu_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_arbiter_if.sv
// Requester and FPU-side signals of the shared FPU arbiter.
// slave is the arbiter view; master is the environment view.
interface fpu_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]    req;
  logic [16*N-1:0] req_a;
  logic [16*N-1:0] req_b;
  logic [2*N-1:0]  req_op;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic [15:0]     res_data;
  logic            res_err;
  logic            res_timeout;
  logic            busy;
  logic            fpu_start;
  logic [15:0]     fpu_data;
  logic            fpu_ready;
  logic            fpu_error;
  logic [15:0]     fpu_result;

  modport slave (
    input  req, req_a, req_b, req_op,
    input  fpu_ready, fpu_error, fpu_result,
    output gnt, done, res_data, res_err,
    output res_timeout, busy, fpu_start, fpu_data
  );

  modport master (
    output req, req_a, req_b, req_op,
    output fpu_ready, fpu_error, fpu_result,
    input  gnt, done, res_data, res_err,
    input  res_timeout, busy, fpu_start, fpu_data
  );
endinterface

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter that serializes one requester's operation
// onto a shared FPU and returns its result, with a watchdog.
module fpu_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 64
) (
  input logic         clk,
  input logic         rst,
  fpu_arbiter_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [IW:0]   NL    = (IW+1)'(N);
  localparam logic [IW-1:0] LAST  = IW'(N-1);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT-1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SEND_A = 3'd1;
  localparam logic [2:0] SEND_B = 3'd2;
  localparam logic [2:0] SEND_O = 3'd3;
  localparam logic [2:0] WAIT   = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  logic [2:0]    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] idx;
  logic [IW-1:0] win;
  logic          found;
  logic [IW:0]   j;
  logic [15:0]   a_q;
  logic [15:0]   b_q;
  logic [1:0]    op_q;
  logic [CW-1:0] cnt;
  logic [15:0]   res_q;
  logic          err_q;
  logic          tmo_q;
  logic [N-1:0]  sel;

  // First requesting index at or after ptr, wrapping modulo N.
  always_comb begin
    win   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      j = {1'b0, ptr} + (IW+1)'(k);
      if (j >= NL) j = j - NL;
      if (!found && bus.req[j[IW-1:0]]) begin
        found = 1'b1;
        win   = j[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= '0;
      idx   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      cnt   <= '0;
      res_q <= '0;
      err_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            a_q   <= bus.req_a[16*int'(win) +: 16];
            b_q   <= bus.req_b[16*int'(win) +: 16];
            op_q  <= bus.req_op[2*int'(win) +: 2];
            idx   <= win;
            ptr   <= (win == LAST) ? '0 : win + 1'b1;
            state <= SEND_A;
          end
        end
        SEND_A: state <= SEND_B;
        SEND_B: state <= SEND_O;
        SEND_O: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (bus.fpu_ready) begin
            res_q <= bus.fpu_result;
            err_q <= bus.fpu_error;
            tmo_q <= 1'b0;
            state <= DONE;
          end else if (cnt == TLAST) begin
            res_q <= 16'h7E00;
            err_q <= 1'b1;
            tmo_q <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign sel = {{(N-1){1'b0}}, 1'b1} << idx;

  assign bus.gnt         = (state == SEND_A) ? sel : '0;
  assign bus.done        = (state == DONE) ? sel : '0;
  assign bus.fpu_start   = (state == SEND_A);
  assign bus.busy        = (state != IDLE);
  assign bus.res_data    = res_q;
  assign bus.res_err     = err_q;
  assign bus.res_timeout = tmo_q;

  always_comb begin
    bus.fpu_data = 16'h0000;
    unique case (1'b1)
      (state == SEND_A): bus.fpu_data = a_q;
      (state == SEND_B): bus.fpu_data = b_q;
      (state == SEND_O): bus.fpu_data = {14'b0, op_q};
      default:           bus.fpu_data = 16'h0000;
    endcase
  end
endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter: vector table plus
// round-robin, timeout and reset sequences.
module tb_fpu_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;

  fpu_arbiter_if #(.N(N)) bus ();

  fpu_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    int          rk;
    logic [15:0] res;
    logic        err;
    logic        spur;
    int          dcyc;
    logic [15:0] xres;
    logic        xerr;
    logic        xtmo;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", n, a, e);
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit got;
    got = 1'b0;
    bus.req                  = '0;
    bus.req[v.id]            = 1'b1;
    bus.req_a[16*v.id +: 16] = v.a;
    bus.req_b[16*v.id +: 16] = v.b;
    bus.req_op[2*v.id +: 2]  = v.op;
    if (v.spur) begin
      bus.fpu_ready  = 1'b1;
      bus.fpu_error  = 1'b1;
      bus.fpu_result = 16'hFFFF;
    end
    for (int c = 1; c <= 30 && !got; c++) begin
      @(negedge clk);
      bus.fpu_ready  = 1'b0;
      bus.fpu_error  = 1'b0;
      bus.fpu_result = 16'h0000;
      if (c == 1) begin
        chk("gnt", int'(bus.gnt), 1 << v.id);
        chk("start", int'(bus.fpu_start), 1);
        chk("data_a", int'(bus.fpu_data), int'(v.a));
        bus.req    = '0;
        bus.req_a  = '1;
        bus.req_b  = '1;
        bus.req_op = '1;
      end
      if (c == 2) begin
        chk("data_b", int'(bus.fpu_data), int'(v.b));
        chk("start_off", int'(bus.fpu_start), 0);
        if (v.spur) begin
          bus.fpu_ready  = 1'b1;
          bus.fpu_error  = 1'b1;
          bus.fpu_result = 16'hFFFF;
        end
      end
      if (c == 3) chk("data_op", int'(bus.fpu_data), int'(v.op));
      if (c == 4) chk("data_wait", int'(bus.fpu_data), 0);
      if (bus.done != '0) begin
        got = 1'b1;
        chk("done_cyc", c, v.dcyc);
        chk("done_vec", int'(bus.done), 1 << v.id);
        chk("res_data", int'(bus.res_data), int'(v.xres));
        chk("res_err", int'(bus.res_err), int'(v.xerr));
        chk("res_tmo", int'(bus.res_timeout), int'(v.xtmo));
      end else if (c >= 4 && c - 4 == v.rk) begin
        bus.fpu_ready  = 1'b1;
        bus.fpu_error  = v.err;
        bus.fpu_result = v.res;
      end
    end
    if (!got) chk("done_seen", 0, 1);
    @(negedge clk);
    chk("idle_busy", int'(bus.busy), 0);
    chk("held_res", int'(bus.res_data), int'(v.xres));
  endtask

  task automatic wait_gnt(output int g, output int t);
    g = -1;
    t = 0;
    for (int c = 0; c < 40 && g < 0; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (bus.gnt[i]) g = i;
      t = cyc;
    end
  endtask

  initial begin
    int g;
    int t;
    int tp;
    int rr[5];
    int seen;
    checks         = 0;
    errors         = 0;
    rst            = 1'b0;
    bus.req        = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_op     = '0;
    bus.fpu_ready  = 1'b0;
    bus.fpu_error  = 1'b0;
    bus.fpu_result = '0;

    vt[0] = '{0, 16'h3C00, 16'h4000, 2'b00, 2, 16'h4200, 1'b0,
              1'b0, 7, 16'h4200, 1'b0, 1'b0};
    vt[1] = '{2, 16'h1111, 16'h2222, 2'b10, 0, 16'h7C00, 1'b1,
              1'b0, 5, 16'h7C00, 1'b1, 1'b0};
    vt[2] = '{3, 16'hAAAA, 16'h5555, 2'b11, -1, 16'h0000, 1'b0,
              1'b0, 12, 16'h7E00, 1'b1, 1'b1};
    vt[3] = '{1, 16'h0F0F, 16'hF0F0, 2'b01, 7, 16'h1234, 1'b0,
              1'b0, 12, 16'h1234, 1'b0, 1'b0};
    vt[4] = '{1, 16'hBEEF, 16'hCAFE, 2'b10, 1, 16'h5555, 1'b0,
              1'b1, 6, 16'h5555, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_gnt", int'(bus.gnt), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_start", int'(bus.fpu_start), 0);
    chk("rst_data", int'(bus.fpu_data), 0);
    chk("rst_res", int'(bus.res_data), 0);
    chk("rst_err", int'(bus.res_err), 0);
    chk("rst_tmo", int'(bus.res_timeout), 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(vt[i]);

    // Fresh pointer for the round-robin sequence.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    rr = '{0, 1, 2, 3, 0};
    bus.fpu_ready  = 1'b1;
    bus.fpu_error  = 1'b0;
    bus.fpu_result = 16'h0101;
    bus.req        = '1;
    tp             = 0;
    for (int i = 0; i < 5; i++) begin
      wait_gnt(g, t);
      chk("rr_gnt", g, rr[i]);
      if (i > 0) chk("rr_gap", t - tp, 6);
      tp = t;
    end
    bus.req = 4'b0010;
    wait_gnt(g, t);
    chk("rr_one", g, 1);
    bus.req = 4'b1001;
    wait_gnt(g, t);
    chk("rr_ptr2", g, 3);
    bus.req = 4'b0100;
    wait_gnt(g, t);
    chk("pre_rst_gnt", g, 2);
    bus.req       = '0;
    bus.fpu_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("in_wait", int'(bus.busy), 1);
    rst = 1'b0;
    #1;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_start", int'(bus.fpu_start), 0);
    chk("abort_data", int'(bus.fpu_data), 0);
    chk("abort_res", int'(bus.res_data), 0);
    chk("abort_done", int'(bus.done), 0);
    @(negedge clk);
    rst  = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done != '0) seen = 1;
    end
    chk("no_done", seen, 0);
    bus.fpu_ready = 1'b1;
    bus.req       = '1;
    wait_gnt(g, t);
    chk("post_rst_gnt", g, 0);
    bus.req = '0;
    repeat (8) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
endmodule
